// File: rtl/ahblite_interconnect_arbiter.sv
// Per-slave AHB-Lite arbiter: round-robin address-phase grant with burst/lock/INCR
// hold, plus data-phase owner tracking for HRDATA/HRESP return routing.

module ahb_arb_req_dec (
  input  logic       sel_i,
  input  logic [1:0] trans_i,
  output logic       req_o
);
  assign req_o = sel_i & (trans_i != 2'b00);
endmodule

module ahblite_interconnect_arbiter #(
  parameter int MASTER     = 2,
  parameter int MIDX_WIDTH = (MASTER > 1) ? $clog2(MASTER) : 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [MASTER-1:0]     mst_HSEL_i,
  input  logic [2*MASTER-1:0]   mst_HTRANS_i,
  input  logic [3*MASTER-1:0]   mst_HBURST_i,
  input  logic [MASTER-1:0]     mst_HMASTLOCK_i,
  input  logic                  slv_HREADY_i,
  input  logic                  slv_HRESP_i,
  output logic [MASTER-1:0]     mst_grant_o,
  output logic [MIDX_WIDTH-1:0] mst_grant_id_o,
  output logic                  grant_vld_o,
  output logic [MASTER-1:0]     dphase_sel_o,
  output logic                  dphase_vld_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN   = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_LOCK  = 2'd3;

  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BU_INCR   = 3'b001;

  logic [1:0]            state_q, state_d;
  logic [MASTER-1:0]     grant_q, grant_d;
  logic [MIDX_WIDTH-1:0] gid_q, gid_d;
  logic [MIDX_WIDTH-1:0] rr_q, rr_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [MASTER-1:0]     dsel_q, dsel_d;
  logic                  dvld_q, dvld_d;

  logic [MASTER-1:0]     req;
  logic [1:0]            own_trans;
  logic [2:0]            own_burst;
  logic                  own_lock, own_req, gvld, accept;
  logic                  hold_lock, hold_burst, hold_incr, hold;
  logic                  win_found;
  logic [MIDX_WIDTH-1:0] win_id;

  ahb_arb_req_dec u_dec [MASTER-1:0] (
    .sel_i   (mst_HSEL_i),
    .trans_i (mst_HTRANS_i),
    .req_o   (req)
  );

  function automatic logic [3:0] beats_left(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: beats_left = 4'd3;
      3'd4, 3'd5: beats_left = 4'd7;
      3'd6, 3'd7: beats_left = 4'd15;
      default:    beats_left = 4'd0;
    endcase
  endfunction

  assign gvld = (state_q != ST_IDLE);

  always_comb begin
    own_trans = '0;
    own_burst = '0;
    own_lock  = 1'b0;
    own_req   = 1'b0;
    for (int m = 0; m < MASTER; m++) begin
      if (gid_q == MIDX_WIDTH'(m)) begin
        own_trans = mst_HTRANS_i[m*2 +: 2];
        own_burst = mst_HBURST_i[m*3 +: 3];
        own_lock  = mst_HMASTLOCK_i[m];
        own_req   = req[m];
      end
    end
  end

  assign accept = slv_HREADY_i & gvld & own_req;

  // Round-robin: first requester at offset 1..MASTER from the last owner.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 1; i <= MASTER; i++) begin
      for (int m = 0; m < MASTER; m++) begin
        if (!win_found && req[m] && ((int'(rr_q) + i) % MASTER == m)) begin
          win_found = 1'b1;
          win_id    = MIDX_WIDTH'(m);
        end
      end
    end
  end

  // ERROR first cycle kills the remaining burst; err_q masks INCR hold until HREADY.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (slv_HRESP_i && !slv_HREADY_i) begin
      cnt_d = '0;
      err_d = 1'b1;
    end else if (accept) begin
      if (own_trans == TR_NONSEQ)                  cnt_d = beats_left(own_burst);
      else if (own_trans == TR_SEQ && cnt_q != '0) cnt_d = cnt_q - 4'd1;
    end
    if (slv_HREADY_i) err_d = 1'b0;
  end

  assign hold_lock  = gvld & own_lock;
  assign hold_burst = gvld & (cnt_d != '0);
  assign hold_incr  = gvld & ~err_q & (own_burst == BU_INCR) &
                      ((own_trans == TR_SEQ) | (own_trans == TR_BUSY));
  assign hold       = hold_lock | hold_burst | hold_incr;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    rr_d    = rr_q;
    dsel_d  = dsel_q;
    dvld_d  = dvld_q;
    if (slv_HREADY_i) begin
      if (hold) begin
        state_d = own_lock ? ST_LOCK : ST_BURST;
      end else if (win_found) begin
        state_d = ST_OWN;
        gid_d   = win_id;
        for (int m = 0; m < MASTER; m++) grant_d[m] = (win_id == MIDX_WIDTH'(m));
        if (!gvld || win_id != gid_q) rr_d = win_id;
      end else begin
        state_d = ST_IDLE;
        grant_d = '0;
        gid_d   = '0;
      end
      dsel_d = accept ? grant_q : '0;
      dvld_d = accept;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      rr_q    <= MIDX_WIDTH'(MASTER - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
      dsel_q  <= '0;
      dvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      dsel_q  <= dsel_d;
      dvld_q  <= dvld_d;
    end
  end

  assign mst_grant_o    = grant_q;
  assign mst_grant_id_o = gid_q;
  assign grant_vld_o    = gvld;
  assign dphase_sel_o   = dsel_q;
  assign dphase_vld_o   = dvld_q;

endmodule

// File: tb/tb_ahblite_interconnect_arbiter.sv
// Two-master bench: each vector drives one cycle of inputs and queues the
// hand-derived outputs expected after that edge; the scoreboard pops and compares.

module tb_ahblite_interconnect_arbiter;

  localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NSQ = 2'b10, SQ = 2'b11;
  localparam logic [2:0] SGL = 3'd0, INC = 3'd1, I4 = 3'd3, I8 = 3'd5, I16 = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sel = '0;
  logic [3:0] trans = '0;
  logic [5:0] burst = '0;
  logic [1:0] lock = '0;
  logic       rdy = 1'b1;
  logic       rsp = 1'b0;
  logic [1:0] grant, dsel;
  logic [0:0] gid;
  logic       gvld, dvld;

  typedef struct {
    string      tag;
    logic [6:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  ahblite_interconnect_arbiter #(.MASTER(2)) dut (
    .HCLK            (clk),
    .HRESETn         (rst_n),
    .mst_HSEL_i      (sel),
    .mst_HTRANS_i    (trans),
    .mst_HBURST_i    (burst),
    .mst_HMASTLOCK_i (lock),
    .slv_HREADY_i    (rdy),
    .slv_HRESP_i     (rsp),
    .mst_grant_o     (grant),
    .mst_grant_id_o  (gid),
    .grant_vld_o     (gvld),
    .dphase_sel_o    (dsel),
    .dphase_vld_o    (dvld)
  );

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got {grant,id,gvld,dsel,dvld}=%b required %b", tag, got, exp);
    end
  endtask

  // eg/ed: expected grant and data-phase select after this cycle's edge.
  task automatic v(input string tag, input logic rn, input logic [1:0] s,
                   input logic [1:0] t0, input logic [1:0] t1,
                   input logic [2:0] b0, input logic [2:0] b1, input logic [1:0] lk,
                   input logic r, input logic e, input logic [1:0] eg, input logic [1:0] ed);
    exp_t x;
    @(negedge clk);
    rst_n = rn; sel = s; trans = {t1, t0}; burst = {b1, b0}; lock = lk; rdy = r; rsp = e;
    x.tag = tag;
    x.val = {eg, eg[1], |eg, ed, |ed};
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_noexp"}, {grant, gid, gvld, dsel, dvld}, 7'h7f);
    end else begin
      x = exp_q.pop_front();
      chk(x.tag, {grant, gid, gvld, dsel, dvld}, x.val);
    end
  endtask

  initial begin
    // single master, three SINGLE transfers; HSEL low means no request
    v("s1_rst",   0, 2'b11, IDL, IDL, SGL, SGL, 2'b00, 1, 0, 2'b00, 2'b00);
    v("s1_nosel", 1, 2'b00, NSQ, IDL, SGL, SGL, 2'b00, 1, 0, 2'b00, 2'b00);
    v("s1_grant", 1, 2'b11, NSQ, IDL, SGL, SGL, 2'b00, 1, 0, 2'b01, 2'b00);
    for (int i = 0; i < 3; i++)
      v($sformatf("s1_xfer%0d", i), 1, 2'b11, NSQ, IDL, SGL, SGL, 2'b00, 1, 0, 2'b01, 2'b01);
    v("s1_idle",  1, 2'b11, IDL, IDL, SGL, SGL, 2'b00, 1, 0, 2'b00, 2'b00);

    // contention: strict alternation, master 0 wins the first tie
    v("s2_rst",   0, 2'b11, IDL, IDL, SGL, SGL, 2'b00, 1, 0, 2'b00, 2'b00);
    v("s2_c1",    1, 2'b11, NSQ, NSQ, SGL, SGL, 2'b00, 1, 0, 2'b01, 2'b00);
    for (int i = 0; i < 4; i++)
      v($sformatf("s2_alt%0d", i), 1, 2'b11, NSQ, NSQ, SGL, SGL, 2'b00, 1, 0,
        i[0] ? 2'b01 : 2'b10, i[0] ? 2'b10 : 2'b01);
    v("s2_idle",  1, 2'b11, IDL, IDL, SGL, SGL, 2'b00, 1, 0, 2'b00, 2'b00);

    // INCR4 with one wait state per beat, m1 waiting
    v("s3_rst",   0, 2'b11, IDL, IDL, SGL, SGL, 2'b00, 1, 0, 2'b00, 2'b00);
    v("s3_grant", 1, 2'b11, NSQ, NSQ, I4,  SGL, 2'b00, 1, 0, 2'b01, 2'b00);
    v("s3_b1",    1, 2'b11, NSQ, NSQ, I4,  SGL, 2'b00, 1, 0, 2'b01, 2'b01);
    v("s3_w2",    1, 2'b11, SQ,  NSQ, I4,  SGL, 2'b00, 0, 0, 2'b01, 2'b01);
    v("s3_b2",    1, 2'b11, SQ,  NSQ, I4,  SGL, 2'b00, 1, 0, 2'b01, 2'b01);
    v("s3_w3",    1, 2'b11, SQ,  NSQ, I4,  SGL, 2'b00, 0, 0, 2'b01, 2'b01);
    v("s3_b3",    1, 2'b11, SQ,  NSQ, I4,  SGL, 2'b00, 1, 0, 2'b01, 2'b01);
    v("s3_w4",    1, 2'b11, SQ,  NSQ, I4,  SGL, 2'b00, 0, 0, 2'b01, 2'b01);
    v("s3_b4",    1, 2'b11, SQ,  NSQ, I4,  SGL, 2'b00, 1, 0, 2'b10, 2'b01);
    v("s3_wlast", 1, 2'b11, IDL, NSQ, I4,  SGL, 2'b00, 0, 0, 2'b10, 2'b01);
    v("s3_m1",    1, 2'b11, IDL, NSQ, SGL, SGL, 2'b00, 1, 0, 2'b10, 2'b10);
    v("s3_idle",  1, 2'b11, IDL, IDL, SGL, SGL, 2'b00, 1, 0, 2'b00, 2'b00);

    // locked pair from m1 while m0 requests
    v("s4_rst",   0, 2'b11, IDL, IDL, SGL, SGL, 2'b00, 1, 0, 2'b00, 2'b00);
    v("s4_grant", 1, 2'b11, IDL, NSQ, SGL, SGL, 2'b10, 1, 0, 2'b10, 2'b00);
    v("s4_lk1",   1, 2'b11, NSQ, NSQ, SGL, SGL, 2'b10, 1, 0, 2'b10, 2'b10);
    v("s4_lk2",   1, 2'b11, NSQ, NSQ, SGL, SGL, 2'b10, 1, 0, 2'b10, 2'b10);
    v("s4_unlk",  1, 2'b11, NSQ, IDL, SGL, SGL, 2'b00, 1, 0, 2'b01, 2'b00);
    v("s4_m0",    1, 2'b11, NSQ, IDL, SGL, SGL, 2'b00, 1, 0, 2'b01, 2'b01);
    v("s4_idle",  1, 2'b11, IDL, IDL, SGL, SGL, 2'b00, 1, 0, 2'b00, 2'b00);

    // INCR8 aborted by ERROR on beat 3
    v("s5_rst",   0, 2'b11, IDL, IDL, SGL, SGL, 2'b00, 1, 0, 2'b00, 2'b00);
    v("s5_grant", 1, 2'b11, NSQ, NSQ, I8,  SGL, 2'b00, 1, 0, 2'b01, 2'b00);
    v("s5_b1",    1, 2'b11, NSQ, NSQ, I8,  SGL, 2'b00, 1, 0, 2'b01, 2'b01);
    v("s5_b2",    1, 2'b11, SQ,  NSQ, I8,  SGL, 2'b00, 1, 0, 2'b01, 2'b01);
    v("s5_b3",    1, 2'b11, SQ,  NSQ, I8,  SGL, 2'b00, 1, 0, 2'b01, 2'b01);
    v("s5_err1",  1, 2'b11, SQ,  NSQ, I8,  SGL, 2'b00, 0, 1, 2'b01, 2'b01);
    v("s5_err2",  1, 2'b11, IDL, NSQ, I8,  SGL, 2'b00, 1, 1, 2'b10, 2'b00);
    v("s5_m1",    1, 2'b11, IDL, NSQ, SGL, SGL, 2'b00, 1, 0, 2'b10, 2'b10);
    v("s5_idle",  1, 2'b11, IDL, IDL, SGL, SGL, 2'b00, 1, 0, 2'b00, 2'b00);

    // undefined-length INCR held through SEQ and BUSY
    v("s6_rst",   0, 2'b11, IDL, IDL, SGL, SGL, 2'b00, 1, 0, 2'b00, 2'b00);
    v("s6_grant", 1, 2'b11, NSQ, IDL, INC, SGL, 2'b00, 1, 0, 2'b01, 2'b00);
    v("s6_ns",    1, 2'b11, NSQ, IDL, INC, SGL, 2'b00, 1, 0, 2'b01, 2'b01);
    v("s6_seq",   1, 2'b11, SQ,  NSQ, INC, SGL, 2'b00, 1, 0, 2'b01, 2'b01);
    v("s6_busy",  1, 2'b11, BSY, NSQ, INC, SGL, 2'b00, 1, 0, 2'b01, 2'b01);
    v("s6_seq2",  1, 2'b11, SQ,  NSQ, INC, SGL, 2'b00, 1, 0, 2'b01, 2'b01);
    v("s6_end",   1, 2'b11, IDL, NSQ, INC, SGL, 2'b00, 1, 0, 2'b10, 2'b00);
    v("s6_m1",    1, 2'b11, IDL, NSQ, SGL, SGL, 2'b00, 1, 0, 2'b10, 2'b10);
    v("s6_idle",  1, 2'b11, IDL, IDL, SGL, SGL, 2'b00, 1, 0, 2'b00, 2'b00);

    // reset in the middle of an INCR16
    v("s7_rst",   0, 2'b11, IDL, IDL, SGL, SGL, 2'b00, 1, 0, 2'b00, 2'b00);
    v("s7_grant", 1, 2'b11, NSQ, IDL, I16, SGL, 2'b00, 1, 0, 2'b01, 2'b00);
    v("s7_b1",    1, 2'b11, NSQ, IDL, I16, SGL, 2'b00, 1, 0, 2'b01, 2'b01);
    v("s7_midrst",0, 2'b11, SQ,  IDL, I16, SGL, 2'b00, 1, 0, 2'b00, 2'b00);
    v("s7_rel",   1, 2'b11, IDL, IDL, SGL, SGL, 2'b00, 1, 0, 2'b00, 2'b00);
    v("s7_regnt", 1, 2'b11, NSQ, IDL, SGL, SGL, 2'b00, 1, 0, 2'b01, 2'b00);
    v("s7_xfer",  1, 2'b11, NSQ, IDL, SGL, SGL, 2'b00, 1, 0, 2'b01, 2'b01);
    v("s7_idle",  1, 2'b11, IDL, IDL, SGL, SGL, 2'b00, 1, 0, 2'b00, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/ahblite_interconnect_arbiter.md
# ahblite_interconnect_arbiter

Per-slave arbiter for the multi-master AHB-Lite interconnect. It instantiates once per slave port and decides which master port owns that slave's address phase. It also tracks which master owns the data phase so HRDATA/HRESP are routed back correctly. Grants are round-robin, held across fixed-length bursts, undefined-length INCR bursts and HMASTLOCK sequences, and change only at transfer boundaries (slave HREADY high).

## Interface
Parameters:
- MASTER, 2, number of master ports competing for this slave (1..16)
- MIDX_WIDTH, $clog2(MASTER) (min 1), width of master index outputs

Ports:
- HCLK  in  1  interconnect clock
- HRESETn  in  1  reset, synchronous, active-low
- mst_HSEL_i  in  MASTER  master m's decoded address targets this slave
- mst_HTRANS_i  in  MASTER×2  HTRANS per master
- mst_HBURST_i  in  MASTER×3  HBURST per master
- mst_HMASTLOCK_i  in  MASTER×1  HMASTLOCK per master
- slv_HREADY_i  in  1  slave HREADY (transfer completes when 1)
- slv_HRESP_i  in  1  slave HRESP (1 = ERROR)
- mst_grant_o  out  MASTER  one-hot address-phase grant, registered
- mst_grant_id_o  out  MIDX_WIDTH  index of granted master (valid when grant_vld_o)
- grant_vld_o  out  1  any grant active
- dphase_sel_o  out  MASTER  one-hot data-phase owner, registered
- dphase_vld_o  out  1  a data phase is in progress

## Operation
- req[m] = mst_HSEL_i[m] & (mst_HTRANS_i[m] != IDLE).
- accept = slv_HREADY_i & grant_vld_o & req[owner] (owner's address phase accepted this cycle).
- States: IDLE (no grant), OWN (granted, re-arbitrable), BURST (fixed burst in progress), LOCK (HMASTLOCK sequence).
- Beat counter, 4 bits. Loaded on accept of NONSEQ with HBURST: WRAP4/INCR4=3, WRAP8/INCR8=7, WRAP16/INCR16=15, SINGLE/INCR=0. Decrements on accept of SEQ, saturating at 0.
- Hold conditions, evaluated at an edge with slv_HREADY_i=1; any true keeps the current owner:
  - owner's mst_HMASTLOCK_i=1 → LOCK;
  - beat counter after update >0 → BURST;
  - owner's HBURST=INCR and owner's HTRANS is SEQ or BUSY.
- Otherwise re-arbitrate among req. Search starts at last owner index+1 and wraps modulo MASTER. The first requester wins. The winner may be the current owner if no other master requests.
- No requests and no hold → grant cleared, state IDLE.
- ERROR response: slv_HRESP_i=1 with slv_HREADY_i=0 clears the beat counter and INCR hold. LOCK is still honoured. Re-arbitration occurs at the following HREADY=1 edge.
- Data phase: on accept, dphase_sel_o ← mst_grant_o and dphase_vld_o ← 1. At an HREADY=1 edge without accept, dphase_vld_o ← 0 and dphase_sel_o ← 0. While HREADY=0, both hold.
- Round-robin pointer updates only when a new grant is issued to a different master.

## Timing
- Reset (HRESETn=0 at an edge): mst_grant_o=0, mst_grant_id_o=0, grant_vld_o=0, dphase_sel_o=0, dphase_vld_o=0, beat counter=0, state IDLE. Pointer=MASTER-1, so master 0 wins the first tie.
- Reset mid-burst or mid-lock: everything drops in the cycle after the reset edge. No completion is performed.
- Grant latency: req rising in cycle n with slave idle/HREADY=1 → mst_grant_o high in cycle n+1. First accept is possible in n+1.
- Grant never changes at an edge with slv_HREADY_i=0.
- Handover at a boundary is zero-bubble: the new owner's grant is visible in the cycle following the previous owner's last accepted address phase.
- dphase_sel_o lags mst_grant_o by exactly one accepted transfer. Both may be set simultaneously to different masters during handover.
- mst_grant_o is always zero or one-hot. dphase_sel_o likewise.

## Test plan
- Single master: m0 issues 3 NONSEQ SINGLE transfers with HREADY=1 → grant m0 in cycle after first req. dphase_sel_o=01 for 3 cycles, then 0.
- Contention: m0 and m1 request continuously with SINGLE, HREADY=1 → grant alternates m0,m1,m0,m1. Each owner sees exactly 1 accepted transfer per grant.
- Fixed burst: m0 issues INCR4 while m1 requests, with 1 wait state per beat → m0 holds for all 4 beats (8 cycles). m1 is granted the cycle after m0's 4th address-phase accept.
- Lock: m1 asserts HMASTLOCK across two SINGLE transfers, with m0 requesting → m1 keeps the grant until HMASTLOCK deasserts at an HREADY=1 edge, then m0 is granted.
- ERROR abort: m0 in INCR8, slave returns ERROR on beat 3 (HREADY=0, HRESP=1, then HREADY=1), m1 requesting → m1 granted after the ERROR's second cycle. Beat counter reads 0.
- Reset mid-burst: assert HRESETn=0 during beat 2 of INCR16 → all outputs 0 next cycle. After release, m0 re-requests and is granted 1 cycle later.
